// File: rtl/gf_pkg.sv
// Shared constants, FSM state type and a single GF(2^128) bit-step helper
// for the iterative GCM multiplier.
package gf_pkg;

    localparam int GCM_WIDTH = 128;
    localparam logic [GCM_WIDTH-1:0] GCM_POLY = 128'h87;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // One bit step: conditionally accumulate m into p, then multiply m by t mod P.
    // Returns {m_next, p_next}.
    function automatic logic [2*GCM_WIDTH-1:0] gf_step(
        input logic [GCM_WIDTH-1:0] m,
        input logic [GCM_WIDTH-1:0] p,
        input logic                 ybit
    );
        logic [GCM_WIDTH-1:0] m_n;
        logic [GCM_WIDTH-1:0] p_n;
        p_n = ybit ? (p ^ m) : p;
        m_n = {m[GCM_WIDTH-2:0], 1'b0} ^ (m[GCM_WIDTH-1] ? GCM_POLY : '0);
        return {m_n, p_n};
    endfunction

endpackage

// File: rtl/gf_mult_digit.sv
// Combinational DIGIT-bit slice of the shift-and-add GF(2^WIDTH) multiplier;
// y_digit bit 0 is applied first.
module gf_mult_digit
    import gf_pkg::*;
#(
    parameter int                 WIDTH = GCM_WIDTH,
    parameter int                 DIGIT = 8,
    parameter logic [WIDTH-1:0]   POLY  = WIDTH'(GCM_POLY)
) (
    input  logic [WIDTH-1:0] m,
    input  logic [WIDTH-1:0] p,
    input  logic [DIGIT-1:0] y_digit,
    output logic [WIDTH-1:0] m_next,
    output logic [WIDTH-1:0] p_next
);

    logic [WIDTH-1:0] m_t;
    logic [WIDTH-1:0] p_t;

    always_comb begin
        m_t = m;
        p_t = p;
        for (int i = 0; i < DIGIT; i++) begin
            if (y_digit[i]) begin
                p_t = p_t ^ m_t;
            end
            m_t = {m_t[WIDTH-2:0], 1'b0} ^ (m_t[WIDTH-1] ? POLY : '0);
        end
        m_next = m_t;
        p_next = p_t;
    end

endmodule

// File: rtl/gf_mult_iter.sv
// Iterative GF(2^WIDTH) multiplier with valid/ready on both sides, DIGIT y bits per cycle.
// Define GF_MULT_CHAIN_EN to add in_chain and the result accumulator for GHASH chaining.
module gf_mult_iter
    import gf_pkg::*;
#(
    parameter int                 WIDTH = GCM_WIDTH,
    parameter int                 DIGIT = 8,
    parameter logic [WIDTH-1:0]   POLY  = WIDTH'(GCM_POLY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
`ifdef GF_MULT_CHAIN_EN
    input  logic             in_chain,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_z
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("gf_mult_iter: DIGIT must divide WIDTH");
    end

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] p_reg;
    logic [WIDTH-1:0] y_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] out_z_reg;
    logic [WIDTH-1:0] m_next;
    logic [WIDTH-1:0] p_next;
    logic [WIDTH-1:0] load_x;
    logic             accept;
    logic             last_step;

    assign in_ready  = !rst && ((state_reg == IDLE) || ((state_reg == DONE) && out_ready));
    assign out_valid = (state_reg == DONE);
    assign out_z     = out_z_reg;
    assign accept    = in_valid && in_ready;
    assign last_step = (cnt_reg == CNT_W'(STEPS - 1));

`ifdef GF_MULT_CHAIN_EN
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] chain_src;

    // A result handed off this very cycle has not reached acc_reg yet, so forward it.
    assign chain_src = (state_reg == DONE) ? out_z_reg : acc_reg;
    assign load_x    = in_chain ? (in_x ^ chain_src) : in_x;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg <= '0;
        end else if (out_valid && out_ready) begin
            acc_reg <= out_z_reg;
        end
    end
`else
    assign load_x = in_x;
`endif

    gf_mult_digit #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT),
        .POLY  (POLY)
    ) u_digit (
        .m       (m_reg),
        .p       (p_reg),
        .y_digit (y_reg[DIGIT-1:0]),
        .m_next  (m_next),
        .p_next  (p_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = accept ? BUSY : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_reg     <= '0;
            p_reg     <= '0;
            y_reg     <= '0;
            cnt_reg   <= '0;
            out_z_reg <= '0;
        end else if (accept) begin
            m_reg   <= load_x;
            p_reg   <= '0;
            y_reg   <= in_y;
            cnt_reg <= '0;
        end else if (state_reg == BUSY) begin
            m_reg   <= m_next;
            p_reg   <= p_next;
            y_reg   <= y_reg >> DIGIT;
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (last_step) begin
                out_z_reg <= p_next;
            end
        end
    end

endmodule
